// File: rtl/regset_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regset_feeder_pkg
// Brief    : Shared widths and state encoding for the register-set feeder.
// Revision : 1.0 - initial release
// ============================================================================
package regset_feeder_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HAVE_LO = 2'd1,
        ST_WRITE   = 2'd2
    } state_e;

endpackage : regset_feeder_pkg
`default_nettype wire

// File: rtl/regset_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : regset_feeder_if
// Brief    : Command/data bundle between the control unit and the feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface regset_feeder_if;
    import regset_feeder_pkg::*;

    logic [BYTE_W-1:0] i_bus;
    logic              i_push;
    logic              i_commit;
    logic              i_incr;
    logic              i_decr;
    logic              i_target;
    logic [WORD_W-1:0] i_regVal;
    logic [WORD_W-1:0] o_d;
    logic              o_write0;
    logic              o_write1;
    logic              o_busy;
    logic              o_half;
    logic              o_wrap;

    // Control unit side: issues commands, observes status.
    modport master (
        output i_bus, i_push, i_commit, i_incr, i_decr, i_target, i_regVal,
        input  o_d, o_write0, o_write1, o_busy, o_half, o_wrap
    );

    // Feeder side.
    modport slave (
        input  i_bus, i_push, i_commit, i_incr, i_decr, i_target, i_regVal,
        output o_d, o_write0, o_write1, o_busy, o_half, o_wrap
    );

endinterface : regset_feeder_if
`default_nettype wire

// File: rtl/regset_feeder_incdec16.sv
`default_nettype none
// ============================================================================
// Module   : incdec16
// Brief    : 16-bit add/subtract of a step with carry/borrow-out as wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
module incdec16
    import regset_feeder_pkg::*;
(
    input  wire logic [WORD_W-1:0] i_value,
    input  wire logic [WORD_W-1:0] i_step,
    input  wire logic              i_dir,     // 0 = increment, 1 = decrement
    output logic      [WORD_W-1:0] o_result,
    output logic                   o_wrap
);

    logic [WORD_W:0] w_ext;

    // The extra top bit is the carry on increment and the borrow on decrement.
    always_comb begin
        if (i_dir) begin
            w_ext = {1'b0, i_value} - {1'b0, i_step};
        end else begin
            w_ext = {1'b0, i_value} + {1'b0, i_step};
        end
    end

    assign o_result = w_ext[WORD_W-1:0];
    assign o_wrap   = w_ext[WORD_W];

endmodule : incdec16
`default_nettype wire

// File: rtl/regset_feeder.sv
`default_nettype none
// ============================================================================
// Module   : regset_feeder
// Brief    : Assembles 16-bit words from byte pushes or +/-STEP updates and
//            issues a one-cycle write strobe to the selected register.
// Revision : 1.0 - initial release
// ============================================================================
module regset_feeder
    import regset_feeder_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VAL = 16'hFFFF,
    parameter int unsigned       STEP      = 1
) (
    input  wire logic       i_clk,
    input  wire logic       i_nReset,
    regset_feeder_if.slave  rs
);

    localparam logic [1:0]        c_IDLE    = ST_IDLE;
    localparam logic [1:0]        c_HAVE_LO = ST_HAVE_LO;
    localparam logic [1:0]        c_WRITE   = ST_WRITE;
    localparam logic [WORD_W-1:0] c_STEP    = WORD_W'(STEP);

    logic [1:0]        r_state;
    logic [WORD_W-1:0] r_stage;
    logic              r_target;
    logic              r_wrap;

    logic              w_arith;
    logic [WORD_W-1:0] w_result;
    logic              w_wrap;

    // incr outranks decr, so the direction is decrement only when incr is low.
    assign w_arith = rs.i_incr | rs.i_decr;

    incdec16 u_incdec (
        .i_value  (rs.i_regVal),
        .i_step   (c_STEP),
        .i_dir    (~rs.i_incr),
        .o_result (w_result),
        .o_wrap   (w_wrap)
    );

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state  <= c_IDLE;
            r_stage  <= RESET_VAL;
            r_target <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_HAVE_LO: begin
                    if (w_arith) begin
                        // Any partially assembled word is abandoned.
                        r_stage  <= w_result;
                        r_wrap   <= w_wrap;
                        r_target <= rs.i_target;
                        r_state  <= c_WRITE;
                    end else if (rs.i_push) begin
                        if (r_state == c_IDLE) begin
                            r_stage[BYTE_W-1:0] <= rs.i_bus;
                            r_target            <= rs.i_target;
                            r_wrap              <= 1'b0;
                            r_state             <= c_HAVE_LO;
                        end else begin
                            r_stage[WORD_W-1:BYTE_W] <= rs.i_bus;
                            r_state                  <= c_WRITE;
                        end
                    end else if (rs.i_commit) begin
                        if (r_state == c_IDLE) begin
                            r_target <= rs.i_target;
                        end else begin
                            r_stage[WORD_W-1:BYTE_W] <= '0;
                        end
                        r_state <= c_WRITE;
                    end
                end
                c_WRITE: r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign rs.o_d      = r_stage;
    assign rs.o_busy   = (r_state == c_WRITE);
    assign rs.o_half   = (r_state == c_HAVE_LO);
    assign rs.o_write0 = (r_state == c_WRITE) & ~r_target;
    assign rs.o_write1 = (r_state == c_WRITE) &  r_target;
    assign rs.o_wrap   = r_wrap;

endmodule : regset_feeder
`default_nettype wire

// File: tb/tb_regset_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_regset_feeder
// Brief    : Directed and randomized self-checking bench for regset_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regset_feeder;

    localparam int STEP = 1;

    logic clk;
    logic nreset;
    int   total;
    int   bad;

    // Reference model state, kept as plain integers.
    int   m_stage;
    bit   m_lo_held;
    bit   m_writing;
    bit   m_target;
    bit   m_wrap;

    regset_feeder_if rf ();

    regset_feeder #(
        .RESET_VAL (16'hFFFF),
        .STEP      (STEP)
    ) dut (
        .i_clk    (clk),
        .i_nReset (nreset),
        .rs       (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_cmd(input bit push, input bit commit, input bit incr, input bit decr,
                           input bit tgt, input logic [7:0] bus, input logic [15:0] regval);
        rf.i_push   = push;
        rf.i_commit = commit;
        rf.i_incr   = incr;
        rf.i_decr   = decr;
        rf.i_target = tgt;
        rf.i_bus    = bus;
        rf.i_regVal = regval;
    endtask

    task automatic idle_cmd();
        set_cmd(0, 0, 0, 0, 0, 8'h00, 16'h0000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies one clock edge worth of the behavioural rules to the model.
    task automatic model_edge(input bit push, input bit commit, input bit incr, input bit decr,
                              input bit tgt, input int bus, input int regval);
        int sum;
        if (m_writing) begin
            m_writing = 0;
        end else if (incr || decr) begin
            sum       = incr ? regval + STEP : regval - STEP;
            m_wrap    = (sum > 65535) || (sum < 0);
            m_stage   = (sum + 65536) % 65536;
            m_target  = tgt;
            m_lo_held = 0;
            m_writing = 1;
        end else if (push) begin
            if (m_lo_held) begin
                m_stage   = (m_stage % 256) + bus * 256;
                m_lo_held = 0;
                m_writing = 1;
            end else begin
                m_stage   = (m_stage / 256) * 256 + bus;
                m_target  = tgt;
                m_wrap    = 0;
                m_lo_held = 1;
            end
        end else if (commit) begin
            if (m_lo_held) begin
                m_stage   = m_stage % 256;
                m_lo_held = 0;
            end else begin
                m_target = tgt;
            end
            m_writing = 1;
        end
    endtask

    task automatic test_reset();
        idle_cmd();
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rf.o_d !== 16'hFFFF) begin
            bad++; $display("FAIL reset_d: got %h want ffff", rf.o_d);
        end
        total++;
        if ({rf.o_write0, rf.o_write1, rf.o_busy, rf.o_half, rf.o_wrap} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000",
                            {rf.o_write0, rf.o_write1, rf.o_busy, rf.o_half, rf.o_wrap});
        end
        #2 nreset = 1'b1;
        tick();
    endtask

    task automatic test_push_pair();
        set_cmd(1, 0, 0, 0, 1, 8'h34, 16'h0000);
        tick();
        total++;
        if (rf.o_half !== 1'b1 || rf.o_busy !== 1'b0) begin
            bad++; $display("FAIL pair_half: half=%b busy=%b want 1 0", rf.o_half, rf.o_busy);
        end
        set_cmd(1, 0, 0, 0, 0, 8'h12, 16'h0000);
        tick();
        total++;
        if (rf.o_d !== 16'h1234) begin
            bad++; $display("FAIL pair_d: got %h want 1234", rf.o_d);
        end
        total++;
        if ({rf.o_write1, rf.o_write0, rf.o_half} !== 3'b100) begin
            bad++; $display("FAIL pair_strobe: w1w0half=%b want 100",
                            {rf.o_write1, rf.o_write0, rf.o_half});
        end
        idle_cmd();
        tick();
        total++;
        if ({rf.o_write1, rf.o_write0, rf.o_busy} !== 3'b000) begin
            bad++; $display("FAIL pair_one_cycle: w1w0busy=%b want 000",
                            {rf.o_write1, rf.o_write0, rf.o_busy});
        end
    endtask

    task automatic test_incdec_wrap();
        set_cmd(0, 0, 1, 0, 0, 8'h00, 16'hFFFF);
        tick();
        total++;
        if (rf.o_d !== 16'h0000 || rf.o_wrap !== 1'b1) begin
            bad++; $display("FAIL incr_wrap: d=%h wrap=%b want 0000 1", rf.o_d, rf.o_wrap);
        end
        total++;
        if ({rf.o_write0, rf.o_write1} !== 2'b10) begin
            bad++; $display("FAIL incr_strobe: w0w1=%b want 10", {rf.o_write0, rf.o_write1});
        end
        idle_cmd();
        tick();
        set_cmd(0, 0, 0, 1, 0, 8'h00, 16'h0010);
        tick();
        total++;
        if (rf.o_d !== 16'h000F || rf.o_wrap !== 1'b0 || rf.o_write0 !== 1'b1) begin
            bad++; $display("FAIL decr: d=%h wrap=%b w0=%b want 000f 0 1",
                            rf.o_d, rf.o_wrap, rf.o_write0);
        end
        idle_cmd();
        tick();
    endtask

    task automatic test_push_commit();
        int strobes;
        strobes = 0;
        set_cmd(1, 0, 0, 0, 0, 8'hAB, 16'h0000);
        tick();
        set_cmd(0, 1, 0, 0, 1, 8'h00, 16'h0000);
        tick();
        total++;
        if (rf.o_d !== 16'h00AB || rf.o_write0 !== 1'b1) begin
            bad++; $display("FAIL commit_zext: d=%h w0=%b want 00ab 1", rf.o_d, rf.o_write0);
        end
        strobes += int'(rf.o_write0) + int'(rf.o_write1);
        // A push during the strobe cycle must be dropped.
        set_cmd(1, 0, 0, 0, 1, 8'h77, 16'h0000);
        tick();
        strobes += int'(rf.o_write0) + int'(rf.o_write1);
        total++;
        if (rf.o_half !== 1'b0 || rf.o_busy !== 1'b0 || rf.o_d !== 16'h00AB) begin
            bad++; $display("FAIL busy_push: half=%b busy=%b d=%h want 0 0 00ab",
                            rf.o_half, rf.o_busy, rf.o_d);
        end
        idle_cmd();
        tick();
        strobes += int'(rf.o_write0) + int'(rf.o_write1);
        total++;
        if (strobes !== 1) begin
            bad++; $display("FAIL commit_strobes: got %0d want 1", strobes);
        end
    endtask

    task automatic test_priority();
        set_cmd(1, 1, 1, 1, 1, 8'hEE, 16'h0100);
        tick();
        total++;
        if (rf.o_d !== 16'h0101 || rf.o_write1 !== 1'b1 || rf.o_wrap !== 1'b0) begin
            bad++; $display("FAIL priority: d=%h w1=%b wrap=%b want 0101 1 0",
                            rf.o_d, rf.o_write1, rf.o_wrap);
        end
        idle_cmd();
        tick();
    endtask

    task automatic test_async_reset();
        int strobes;
        strobes = 0;
        set_cmd(1, 0, 0, 0, 0, 8'h55, 16'h0000);
        tick();
        idle_cmd();
        total++;
        if (rf.o_half !== 1'b1 || rf.o_d !== 16'h0155) begin
            bad++; $display("FAIL pre_reset: half=%b d=%h want 1 0155", rf.o_half, rf.o_d);
        end
        #2 nreset = 1'b0;
        #1;
        total++;
        if (rf.o_d !== 16'hFFFF || rf.o_half !== 1'b0) begin
            bad++; $display("FAIL async_reset: d=%h half=%b want ffff 0", rf.o_d, rf.o_half);
        end
        tick();
        #2 nreset = 1'b1;
        repeat (3) begin
            tick();
            strobes += int'(rf.o_write0) + int'(rf.o_write1) + int'(rf.o_half);
        end
        total++;
        if (strobes !== 0) begin
            bad++; $display("FAIL post_reset_strobe: got %0d want 0", strobes);
        end
    endtask

    task automatic test_idle_commit();
        set_cmd(0, 1, 0, 0, 0, 8'h00, 16'h0000);
        tick();
        idle_cmd();
        total++;
        if (rf.o_d !== 16'hFFFF || {rf.o_write0, rf.o_write1} !== 2'b10) begin
            bad++; $display("FAIL idle_commit: d=%h w0w1=%b want ffff 10",
                            rf.o_d, {rf.o_write0, rf.o_write1});
        end
        tick();
        total++;
        if ({rf.o_write0, rf.o_write1} !== 2'b00) begin
            bad++; $display("FAIL idle_commit_end: w0w1=%b want 00", {rf.o_write0, rf.o_write1});
        end
    endtask

    task automatic test_random();
        bit          p, c, inc, dec, t;
        logic [7:0]  b;
        logic [15:0] rv;
        int          exp_w0, exp_w1;
        idle_cmd();
        nreset = 1'b0;
        #3 nreset = 1'b1;
        m_stage = 16'hFFFF; m_lo_held = 0; m_writing = 0; m_target = 0; m_wrap = 0;
        for (int i = 0; i < 400; i++) begin
            p   = ($urandom_range(0, 2) == 0);
            c   = ($urandom_range(0, 4) == 0);
            inc = ($urandom_range(0, 6) == 0);
            dec = ($urandom_range(0, 6) == 0);
            t   = 1'($urandom_range(0, 1));
            b   = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rv = 16'hFFFF;
                1:       rv = 16'h0000;
                default: rv = 16'($urandom);
            endcase
            set_cmd(p, c, inc, dec, t, b, rv);
            @(posedge clk);
            model_edge(p, c, inc, dec, t, int'(b), int'(rv));
            #1;
            exp_w0 = (m_writing && !m_target) ? 1 : 0;
            exp_w1 = (m_writing &&  m_target) ? 1 : 0;
            total++;
            if (int'(rf.o_d) !== m_stage) begin
                bad++; $display("FAIL rand_d[%0d]: got %h want %h", i, rf.o_d, m_stage[15:0]);
            end
            total++;
            if (int'(rf.o_write0) !== exp_w0 || int'(rf.o_write1) !== exp_w1) begin
                bad++; $display("FAIL rand_strobe[%0d]: w0w1=%b%b want %0d%0d",
                                i, rf.o_write0, rf.o_write1, exp_w0, exp_w1);
            end
            total++;
            if (rf.o_busy !== m_writing || rf.o_half !== m_lo_held) begin
                bad++; $display("FAIL rand_state[%0d]: busy=%b half=%b want %b %b",
                                i, rf.o_busy, rf.o_half, m_writing, m_lo_held);
            end
            total++;
            if (rf.o_wrap !== m_wrap) begin
                bad++; $display("FAIL rand_wrap[%0d]: got %b want %b", i, rf.o_wrap, m_wrap);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        nreset = 1'b1;
        idle_cmd();
        #1;
        test_reset();
        test_push_pair();
        test_incdec_wrap();
        test_push_commit();
        test_priority();
        test_async_reset();
        test_idle_commit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regset_feeder
`default_nettype wire
